// File: rtl/abs_diff_error_monitor.sv
// Sweeps every input vector through an external approximate |A-B| candidate and
// accumulates error statistics against the exact absolute difference.
module abs_diff_error_monitor #(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 2,
    parameter int unsigned ET    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [IN_W-1:0]       dut_in,
    input  logic [OUT_W-1:0]      dut_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [OUT_W-1:0]      max_err,
    output logic [IN_W+OUT_W-1:0] err_sum,
    output logic [IN_W:0]         viol_cnt,
    output logic [IN_W-1:0]       first_fail_vec,
    output logic                  first_fail_valid
);

    localparam int unsigned HALF  = IN_W / 2;
    localparam int unsigned SUM_W = IN_W + OUT_W;

    typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} state_e;

    state_e           state_q, state_d;
    logic [IN_W-1:0]  dut_in_q, dut_in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [OUT_W-1:0] max_err_q, max_err_d;
    logic [SUM_W-1:0] err_sum_q, err_sum_d;
    logic [IN_W:0]    viol_cnt_q, viol_cnt_d;
    logic [IN_W-1:0]  ff_vec_q, ff_vec_d;
    logic             ff_valid_q, ff_valid_d;
    logic [IN_W-1:0]  s1_vec_q, s1_vec_d;
    logic [OUT_W-1:0] s1_out_q, s1_out_d;
    logic             s1_valid_q, s1_valid_d;

    logic [OUT_W-1:0] op_a, op_b, exact, err;

    always_comb begin
        op_a  = s1_vec_q[HALF-1:0];
        op_b  = s1_vec_q[IN_W-1:HALF];
        exact = (op_a >= op_b) ? op_a - op_b : op_b - op_a;
        // Compare before subtracting so the error never wraps.
        err   = (exact >= s1_out_q) ? exact - s1_out_q : s1_out_q - exact;
    end

    always_comb begin
        state_d    = state_q;
        dut_in_d   = dut_in_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        max_err_d  = max_err_q;
        err_sum_d  = err_sum_q;
        viol_cnt_d = viol_cnt_q;
        ff_vec_d   = ff_vec_q;
        ff_valid_d = ff_valid_q;
        s1_vec_d   = s1_vec_q;
        s1_out_d   = s1_out_q;
        s1_valid_d = s1_valid_q;

        if (s1_valid_q) begin
            if (err > max_err_q) max_err_d = err;
            err_sum_d = err_sum_q + SUM_W'(err);
            if (32'(err) > ET) begin
                viol_cnt_d = viol_cnt_q + (IN_W + 1)'(1);
                if (!ff_valid_q) begin
                    ff_vec_d   = s1_vec_q;
                    ff_valid_d = 1'b1;
                end
            end
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StSweep;
                    dut_in_d   = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    max_err_d  = '0;
                    err_sum_d  = '0;
                    viol_cnt_d = '0;
                    ff_vec_d   = '0;
                    ff_valid_d = 1'b0;
                end
            end
            StSweep: begin
                s1_vec_d   = dut_in_q;
                s1_out_d   = dut_out;
                s1_valid_d = 1'b1;
                if (&dut_in_q) begin
                    dut_in_d = '0;
                    state_d  = StDrain;
                end else begin
                    dut_in_d = dut_in_q + IN_W'(1);
                end
            end
            StDrain: begin
                s1_valid_d = 1'b0;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                pass_d     = (viol_cnt_d == '0);
                state_d    = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            dut_in_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            max_err_q  <= '0;
            err_sum_q  <= '0;
            viol_cnt_q <= '0;
            ff_vec_q   <= '0;
            ff_valid_q <= 1'b0;
            s1_vec_q   <= '0;
            s1_out_q   <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dut_in_q   <= dut_in_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            max_err_q  <= max_err_d;
            err_sum_q  <= err_sum_d;
            viol_cnt_q <= viol_cnt_d;
            ff_vec_q   <= ff_vec_d;
            ff_valid_q <= ff_valid_d;
            s1_vec_q   <= s1_vec_d;
            s1_out_q   <= s1_out_d;
            s1_valid_q <= s1_valid_d;
        end
    end

    assign dut_in           = dut_in_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign max_err          = max_err_q;
    assign err_sum          = err_sum_q;
    assign viol_cnt         = viol_cnt_q;
    assign first_fail_vec   = ff_vec_q;
    assign first_fail_valid = ff_valid_q;

endmodule

// File: tb/tb_abs_diff_error_monitor.sv
// Directed bench: two monitors (ET=1 and default ET=3) watch the same candidate model.
module tb_abs_diff_error_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    int         mode = 0;  // 0: exact, 1: constant 0, 2: constant 3

    logic [3:0] dut_in1, dut_in3;
    logic [1:0] dut_out1, dut_out3;
    logic       busy1, done1, pass1, busy3, done3, pass3;
    logic [1:0] max_err1, max_err3;
    logic [5:0] err_sum1, err_sum3;
    logic [4:0] viol_cnt1, viol_cnt3;
    logic [3:0] ffv1, ffv3;
    logic       ffok1, ffok3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [1:0] cand(input int m, input logic [3:0] v);
        logic [1:0] a, b;
        a = v[1:0];
        b = v[3:2];
        case (m)
            0:       return (a >= b) ? a - b : b - a;
            1:       return 2'd0;
            default: return 2'd3;
        endcase
    endfunction

    assign dut_out1 = cand(mode, dut_in1);
    assign dut_out3 = cand(mode, dut_in3);

    abs_diff_error_monitor #(.IN_W(4), .OUT_W(2), .ET(1)) u_et1 (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in1), .dut_out(dut_out1),
        .busy(busy1), .done(done1), .pass(pass1), .max_err(max_err1), .err_sum(err_sum1),
        .viol_cnt(viol_cnt1), .first_fail_vec(ffv1), .first_fail_valid(ffok1)
    );

    abs_diff_error_monitor u_et3 (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in3), .dut_out(dut_out3),
        .busy(busy3), .done(done3), .pass(pass3), .max_err(max_err3), .err_sum(err_sum3),
        .viol_cnt(viol_cnt3), .first_fail_vec(ffv3), .first_fail_valid(ffok3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pulse start for one edge, then count edges until done (bounded).
    task automatic run_sweep(output int edges);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        while (!done1 && edges < 100) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
    endtask

    typedef struct {
        int         m;
        logic [1:0] max_e;
        logic [5:0] sum;
        logic [4:0] viol1;
        logic [3:0] ffv;
        logic       ffok;
        logic       pass1;
    } vec_t;

    vec_t tbl[3];

    initial begin
        int edges;
        int busy_cycles;

        tbl[0] = '{m: 0, max_e: 2'd0, sum: 6'd0,  viol1: 5'd0,  ffv: 4'h0, ffok: 1'b0, pass1: 1'b1};
        tbl[1] = '{m: 1, max_e: 2'd3, sum: 6'd20, viol1: 5'd6,  ffv: 4'h2, ffok: 1'b1, pass1: 1'b0};
        tbl[2] = '{m: 2, max_e: 2'd3, sum: 6'd28, viol1: 5'd10, ffv: 4'h0, ffok: 1'b1, pass1: 1'b0};

        repeat (2) @(negedge clk);
        chk("reset dut_in", 32'(dut_in1), 32'd0);
        chk("reset busy/done/pass", {busy1, done1, pass1}, 3'b000);
        chk("reset err_sum", 32'(err_sum1), 32'd0);
        chk("reset first_fail_valid", 32'(ffok1), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            mode = tbl[i].m;
            run_sweep(edges);
            chk($sformatf("v%0d latency", i), 32'(edges), 32'd17);
            chk($sformatf("v%0d max_err", i), 32'(max_err1), 32'(tbl[i].max_e));
            chk($sformatf("v%0d err_sum", i), 32'(err_sum1), 32'(tbl[i].sum));
            chk($sformatf("v%0d viol_cnt", i), 32'(viol_cnt1), 32'(tbl[i].viol1));
            chk($sformatf("v%0d first_fail_valid", i), 32'(ffok1), 32'(tbl[i].ffok));
            if (tbl[i].ffok) chk($sformatf("v%0d first_fail_vec", i), 32'(ffv1), 32'(tbl[i].ffv));
            chk($sformatf("v%0d pass", i), 32'(pass1), 32'(tbl[i].pass1));
            chk($sformatf("v%0d busy", i), 32'(busy1), 32'd0);
            chk($sformatf("v%0d et3 max_err", i), 32'(max_err3), 32'(tbl[i].max_e));
            chk($sformatf("v%0d et3 err_sum", i), 32'(err_sum3), 32'(tbl[i].sum));
            chk($sformatf("v%0d et3 viol_cnt", i), 32'(viol_cnt3), 32'd0);
            chk($sformatf("v%0d et3 pass", i), 32'(pass3), 32'd1);
        end

        // Back-to-back restart from DONE clears results on the accepting edge.
        mode = 1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("b2b done cleared", 32'(done1), 32'd0);
        chk("b2b err_sum cleared", 32'(err_sum1), 32'd0);
        chk("b2b first_fail cleared", 32'(ffok1), 32'd0);
        chk("b2b busy", 32'(busy1), 32'd1);

        // Sequence check with a stray start mid-sweep; count busy cycles.
        busy_cycles = 1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("seq dut_in[%0d]", i), 32'(dut_in1), 32'(i));
            start = (i == 5);
            @(posedge clk);
            @(negedge clk);
            if (busy1) busy_cycles++;
        end
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (busy1) busy_cycles++;
        chk("seq busy cycles", 32'(busy_cycles), 32'd17);
        chk("seq done", 32'(done1), 32'd1);
        chk("seq err_sum", 32'(err_sum1), 32'd20);
        chk("seq viol_cnt", 32'(viol_cnt1), 32'd6);

        // Asynchronous reset mid-sweep.
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("areset dut_in", 32'(dut_in1), 32'd0);
        chk("areset busy/done", {busy1, done1}, 2'b00);
        chk("areset err_sum", 32'(err_sum1), 32'd0);
        chk("areset viol_cnt", 32'(viol_cnt1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("areset idle", 32'(busy1), 32'd0);
        run_sweep(edges);
        chk("post-reset latency", 32'(edges), 32'd17);
        chk("post-reset err_sum", 32'(err_sum1), 32'd20);
        chk("post-reset viol_cnt", 32'(viol_cnt1), 32'd6);
        chk("post-reset first_fail_vec", 32'(ffv1), 32'h2);
        chk("post-reset max_err", 32'(max_err1), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/abs_diff_error_monitor.md
Name: abs_diff_error_monitor

Overview:
Sequential evaluation harness for approximate absolute-difference circuits produced by the SOP/shared-logic synthesis flow. It drives every input vector in turn to an external combinational candidate circuit and reads back its outputs. It compares each result against an internally computed exact |A-B| and accumulates error statistics: maximum error, error sum, violation count against the error threshold, and the first failing vector. It sits on the consumer side of the candidate's interface, alongside candidate netlists in FPGA or emulation sign-off.

Parameters:
IN_W, 4, total candidate input bits; must be even. Operand A = dut_in[IN_W/2-1:0], operand B = dut_in[IN_W-1:IN_W/2].
OUT_W, 2, candidate output width; equals IN_W/2. Bit 0 is the LSB.
ET, 3, error threshold; a vector violates when err > ET.

Ports:
clk  input  1  single clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin a sweep; sampled only in IDLE or DONE.
dut_in  output  IN_W  vector driven to the candidate (registered).
dut_out  input  OUT_W  candidate combinational response to dut_in.
busy  output  1  high in SWEEP and DRAIN.
done  output  1  level, high in DONE until the next accepted start.
pass  output  1  viol_cnt==0; meaningful only while done=1.
max_err  output  OUT_W  largest err seen.
err_sum  output  IN_W+OUT_W  sum of err over all vectors.
viol_cnt  output  IN_W+1  number of vectors with err > ET.
first_fail_vec  output  IN_W  first violating vector in sweep order.
first_fail_valid  output  1  at least one violation captured.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs and internal registers go to 0: dut_in, busy, done, pass, max_err, err_sum, viol_cnt, first_fail_vec, first_fail_valid, s1_valid.
  - Reset mid-sweep aborts the sweep immediately; no partial results are retained.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
  - IDLE/DONE, start=1: go to SWEEP. Set dut_in<=0, busy<=1, done<=0, pass<=0. Clear all accumulators and first_fail_*.
  - SWEEP, each edge: capture s1_vec<=dut_in, s1_out<=dut_out, s1_valid<=1.
    - If dut_in != all-ones: dut_in<=dut_in+1.
    - Else: dut_in<=0, s1 is still captured, state<=DRAIN.
  - DRAIN, one edge: evaluate the final s1, s1_valid<=0, busy<=0, done<=1. Set pass from the updated viol_cnt==0. Go to DONE.
  - DONE: hold all results until start=1.
  - start in SWEEP or DRAIN is ignored.
- Evaluation stage, on every edge with s1_valid=1:
  - A = s1_vec[IN_W/2-1:0], B = s1_vec[IN_W-1:IN_W/2].
  - exact = |A-B|, unsigned, OUT_W bits.
  - err = |exact - s1_out|, OUT_W bits, computed without wrap (compare, then subtract).
  - max_err <= max(max_err, err).
  - err_sum <= err_sum + err.
  - If err > ET: viol_cnt++. If first_fail_valid=0, also set first_fail_vec<=s1_vec and first_fail_valid<=1.
- Timing: the candidate is assumed purely combinational, so dut_out is sampled in the same cycle dut_in is presented.
  - Sweep order is 0..2^IN_W-1 ascending; each vector is sampled exactly once.
- Latency: done rises on the (2^IN_W+1)th rising edge after the edge that accepted start (17 edges for IN_W=4).
- Widths:
  - err_sum never overflows: its maximum is 2^IN_W*(2^OUT_W-1).
  - viol_cnt can reach 2^IN_W.
  - ET >= 2^OUT_W-1 means viol_cnt stays 0.
- Back-to-back: start asserted during the DONE cycle in which done is already high restarts cleanly; results clear on that same edge.

Test Plan:
- Exact candidate (dut_out=|A-B|), ET=1, start -> done after 17 edges; max_err=0, err_sum=0, viol_cnt=0, pass=1, first_fail_valid=0.
- Constant-0 candidate, ET=1 -> max_err=3, err_sum=20, viol_cnt=6, first_fail_vec=4'h2, first_fail_valid=1, pass=0.
- Constant-3 candidate, ET=1 -> max_err=3, err_sum=28, viol_cnt=10, first_fail_vec=4'h0, pass=0.
- Constant-0 candidate, default ET=3 -> viol_cnt=0, pass=1, max_err=3, err_sum=20.
- Check dut_in sequence 0..15 on consecutive cycles; start pulse mid-sweep ignored; busy high for exactly 17 cycles.
- rst_n low at sweep cycle 8 -> all outputs 0 asynchronously, state IDLE; new start gives results identical to an uninterrupted run.
